apb_master_rw: RTL and testbench

Parametrised APB3 master: converts a simple valid/ready command interface (read or write, address, write data) into APB SETUP/ACCESS transfers. Supports slave wait states (pready), error reporting (pslverr), read data return and back-to-back transfers without an intervening IDLE cycle. Sits between an IP-side command source and the APB interconnect, replacing the fixed write-only, no-wait-state master.

---
 rtl/apb_master_rw.sv | 184 ++++++++++++++++++
 tb/tb_apb_master_rw.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_master_rw.sv
// APB3 master: turns a valid/ready read/write command stream into SETUP/ACCESS transfers.
// Optional build macro APBM_TIMEOUT_EN aborts an ACCESS phase stalled for TIMEOUT_CYCLES cycles.
module apb_master_rw #(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                  pclk,
   input  logic                  reset,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_write,
   input  logic [ADDR_WIDTH-1:0] cmd_addr,
   input  logic [DATA_WIDTH-1:0] cmd_wdata,
   output logic                  rsp_valid,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic                  rsp_err,
   output logic                  psel,
   output logic                  penable,
   output logic                  pwrite,
   output logic [ADDR_WIDTH-1:0] paddr,
   output logic [DATA_WIDTH-1:0] pwdata,
   input  logic [DATA_WIDTH-1:0] prdata,
   input  logic                  pready,
   input  logic                  pslverr,
   output logic                  busy
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_SETUP  = 2'b01,
      ST_ACCESS = 2'b10
   } state_e;

   state_e                state_q, state_d;
   logic                  psel_q, psel_d;
   logic                  penable_q, penable_d;
   logic                  pwrite_q, pwrite_d;
   logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
   logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
   logic                  rsp_valid_q, rsp_valid_d;
   logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
   logic                  rsp_err_q, rsp_err_d;
   logic                  busy_q, busy_d;
   logic                  xfer_done_s;

   // Slave response is only meaningful in a fully qualified ACCESS cycle.
   assign xfer_done_s = (state_q == ST_ACCESS) && psel_q && penable_q && pready;
   assign cmd_ready   = (state_q == ST_IDLE) || ((state_q == ST_ACCESS) && pready);

`ifdef APBM_TIMEOUT_EN
   localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
   logic [15:0] tmo_cnt_q, tmo_cnt_d;
   logic        tmo_abort_s;

   assign tmo_abort_s = (state_q == ST_ACCESS) && !pready && (tmo_cnt_q == TMO_LAST);

   // Stall counter: restarts on entry to ACCESS, counts cycles the slave holds pready low.
   always_comb begin
      tmo_cnt_d = tmo_cnt_q;
      if (state_q == ST_SETUP) begin
         tmo_cnt_d = 16'd0;
      end else if ((state_q == ST_ACCESS) && !pready) begin
         tmo_cnt_d = tmo_cnt_q + 16'd1;
      end else begin
         tmo_cnt_d = tmo_cnt_q;
      end
   end
`endif

   // Next-state and registered-output logic for the SETUP/ACCESS sequencer.
   always_comb begin
      state_d     = state_q;
      psel_d      = psel_q;
      penable_d   = penable_q;
      pwrite_d    = pwrite_q;
      paddr_d     = paddr_q;
      pwdata_d    = pwdata_q;
      rsp_valid_d = 1'b0;
      rsp_rdata_d = rsp_rdata_q;
      rsp_err_d   = rsp_err_q;
      case (state_q)
         ST_IDLE: begin
            if (cmd_valid) begin
               state_d   = ST_SETUP;
               psel_d    = 1'b1;
               penable_d = 1'b0;
               pwrite_d  = cmd_write;
               paddr_d   = cmd_addr;
               pwdata_d  = cmd_wdata;
            end else begin
               psel_d    = 1'b0;
               penable_d = 1'b0;
            end
         end
         ST_SETUP: begin
            state_d   = ST_ACCESS;
            psel_d    = 1'b1;
            penable_d = 1'b1;
         end
         ST_ACCESS: begin
            if (xfer_done_s) begin
               rsp_valid_d = 1'b1;
               rsp_err_d   = pslverr;
               rsp_rdata_d = pwrite_q ? {DATA_WIDTH{1'b0}} : prdata;
               // A command taken in the completing cycle goes straight to SETUP with psel held.
               if (cmd_valid) begin
                  state_d   = ST_SETUP;
                  psel_d    = 1'b1;
                  penable_d = 1'b0;
                  pwrite_d  = cmd_write;
                  paddr_d   = cmd_addr;
                  pwdata_d  = cmd_wdata;
               end else begin
                  state_d   = ST_IDLE;
                  psel_d    = 1'b0;
                  penable_d = 1'b0;
               end
`ifdef APBM_TIMEOUT_EN
            end else if (tmo_abort_s) begin
               state_d     = ST_IDLE;
               psel_d      = 1'b0;
               penable_d   = 1'b0;
               rsp_valid_d = 1'b1;
               rsp_err_d   = 1'b1;
               rsp_rdata_d = {DATA_WIDTH{1'b0}};
`endif
            end else begin
               state_d = ST_ACCESS;
            end
         end
         default: begin
            state_d   = ST_IDLE;
            psel_d    = 1'b0;
            penable_d = 1'b0;
         end
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge pclk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         psel_q      <= 1'b0;
         penable_q   <= 1'b0;
         pwrite_q    <= 1'b0;
         paddr_q     <= {ADDR_WIDTH{1'b0}};
         pwdata_q    <= {DATA_WIDTH{1'b0}};
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= {DATA_WIDTH{1'b0}};
         rsp_err_q   <= 1'b0;
         busy_q      <= 1'b0;
`ifdef APBM_TIMEOUT_EN
         tmo_cnt_q   <= 16'd0;
`endif
      end else begin
         state_q     <= state_d;
         psel_q      <= psel_d;
         penable_q   <= penable_d;
         pwrite_q    <= pwrite_d;
         paddr_q     <= paddr_d;
         pwdata_q    <= pwdata_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
         busy_q      <= busy_d;
`ifdef APBM_TIMEOUT_EN
         tmo_cnt_q   <= tmo_cnt_d;
`endif
      end
   end

   assign psel      = psel_q;
   assign penable   = penable_q;
   assign pwrite    = pwrite_q;
   assign paddr     = paddr_q;
   assign pwdata    = pwdata_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_err   = rsp_err_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_apb_master_rw.sv
// Self-checking bench for apb_master_rw: directed protocol scenarios plus a randomized
// command/slave run scored against a transaction-level model.
module tb_apb_master_rw;
   localparam int AW  = 32;
   localparam int DW  = 32;
   localparam int TMO = 4;

   logic          pclk;
   logic          reset;
   logic          cmd_valid;
   logic          cmd_ready;
   logic          cmd_write;
   logic [AW-1:0] cmd_addr;
   logic [DW-1:0] cmd_wdata;
   logic          rsp_valid;
   logic [DW-1:0] rsp_rdata;
   logic          rsp_err;
   logic          psel;
   logic          penable;
   logic          pwrite;
   logic [AW-1:0] paddr;
   logic [DW-1:0] pwdata;
   logic [DW-1:0] prdata;
   logic          pready;
   logic          pslverr;
   logic          busy;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic          wr;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } cmd_t;

   apb_master_rw #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TMO)) dut (
      .pclk(pclk), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
      .prdata(prdata), .pready(pready), .pslverr(pslverr), .busy(busy)
   );

   always #5 pclk = ~pclk;

   // Advance past the next rising edge; outputs are sampled and inputs driven here.
   task automatic tick();
      @(posedge pclk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; cmd_valid = 1'b1; cmd_write = 1'b1;
      cmd_addr = 32'hFFFF_FFFF; cmd_wdata = 32'hFFFF_FFFF; pready = 1'b1; prdata = 32'hFFFF_FFFF;
      tick(); tick();
      total++;
      if ({psel, penable, pwrite, busy, rsp_valid, rsp_err} !== 6'b000000) begin
         bad++; $display("FAIL reset_ctl got=%b exp=000000", {psel, penable, pwrite, busy, rsp_valid, rsp_err});
      end
      total++;
      if (paddr !== 32'h0) begin bad++; $display("FAIL reset_paddr got=%h exp=0", paddr); end
      total++;
      if (pwdata !== 32'h0) begin bad++; $display("FAIL reset_pwdata got=%h exp=0", pwdata); end
      total++;
      if (rsp_rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata got=%h exp=0", rsp_rdata); end
      total++;
      if (cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", cmd_ready); end
      reset = 1'b0; cmd_valid = 1'b0; pready = 1'b0; prdata = 32'h0;
      tick();
      total++;
      if ({psel, busy} !== 2'b00) begin bad++; $display("FAIL reset_idle got=%b exp=00", {psel, busy}); end
   endtask

   task automatic test_write();
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h10; cmd_wdata = 32'hA5A5_0001;
      pready = 1'b1; pslverr = 1'b0; prdata = 32'h1234_5678;
      #1;
      total++;
      if (cmd_ready !== 1'b1) begin bad++; $display("FAIL wr_ready got=%b exp=1", cmd_ready); end
      tick();
      cmd_valid = 1'b0;
      total++;
      if ({psel, penable, busy, pwrite} !== 4'b1011 || paddr !== 32'h10 || pwdata !== 32'hA5A5_0001) begin
         bad++; $display("FAIL wr_setup got=%b/%h/%h exp=1011/00000010/a5a50001", {psel, penable, busy, pwrite}, paddr, pwdata);
      end
      tick();
      total++;
      if ({psel, penable, rsp_valid} !== 3'b110) begin
         bad++; $display("FAIL wr_access got=%b exp=110", {psel, penable, rsp_valid});
      end
      tick();
      total++;
      if ({rsp_valid, rsp_err, psel, busy} !== 4'b1000 || rsp_rdata !== 32'h0) begin
         bad++; $display("FAIL wr_rsp got=%b/%h exp=1000/00000000", {rsp_valid, rsp_err, psel, busy}, rsp_rdata);
      end
      pready = 1'b0;
      tick();
      total++;
      if (rsp_valid !== 1'b0) begin bad++; $display("FAIL wr_pulse got=%b exp=0", rsp_valid); end
   endtask

   task automatic test_read_wait();
      int pen_cycles;
      logic stable_ok;
      pen_cycles = 0; stable_ok = 1'b1;
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h20; cmd_wdata = 32'h0; pready = 1'b0;
      tick();
      cmd_valid = 1'b0; cmd_addr = 32'hBAD0_0000;
      for (int c = 0; c < 3; c++) begin
         tick();
         if (penable === 1'b1) pen_cycles++;
         if (paddr !== 32'h20 || rsp_valid !== 1'b0) stable_ok = 1'b0;
         // Wait cycles carry junk response signals that must be ignored.
         if (c == 2) begin pready = 1'b1; prdata = 32'hDEAD_BEEF; pslverr = 1'b0; end
         else begin prdata = $urandom; pslverr = 1'b1; end
      end
      tick();
      pready = 1'b0; pslverr = 1'b0;
      total++;
      if (pen_cycles != 3 || penable !== 1'b0) begin
         bad++; $display("FAIL rd_penable got=%0d/%b exp=3/0", pen_cycles, penable);
      end
      total++;
      if (stable_ok !== 1'b1) begin bad++; $display("FAIL rd_stable got=%b exp=1", stable_ok); end
      total++;
      if ({rsp_valid, rsp_err} !== 2'b10 || rsp_rdata !== 32'hDEAD_BEEF) begin
         bad++; $display("FAIL rd_rsp got=%b/%h exp=10/deadbeef", {rsp_valid, rsp_err}, rsp_rdata);
      end
   endtask

   task automatic test_back_to_back();
      logic [4:0]    ps, pe, rv;
      logic [AW-1:0] ad [5];
      logic [DW-1:0] wd [5];
      logic          rdy_setup, rdy_access;
      rdy_setup = 1'b1; rdy_access = 1'b0;
      pready = 1'b1; pslverr = 1'b0;
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h100; cmd_wdata = 32'h1111_0000;
      for (int c = 0; c < 5; c++) begin
         tick();
         ps[c] = psel; pe[c] = penable; rv[c] = rsp_valid; ad[c] = paddr; wd[c] = pwdata;
         if (c == 0) begin
            cmd_addr = 32'h104; cmd_wdata = 32'h2222_0000;
            #1 rdy_setup = cmd_ready;
         end else if (c == 1) begin
            rdy_access = cmd_ready;
         end else begin
            cmd_valid = 1'b0;
         end
      end
      pready = 1'b0;
      total++;
      if (ps !== 5'b01111) begin bad++; $display("FAIL b2b_psel got=%b exp=01111", ps); end
      total++;
      if (pe !== 5'b01010) begin bad++; $display("FAIL b2b_penable got=%b exp=01010", pe); end
      total++;
      if (rv !== 5'b10100) begin bad++; $display("FAIL b2b_rsp got=%b exp=10100", rv); end
      total++;
      if (ad[1] !== 32'h100 || ad[2] !== 32'h104 || wd[1] !== 32'h1111_0000 || wd[3] !== 32'h2222_0000) begin
         bad++; $display("FAIL b2b_addr got=%h/%h/%h/%h", ad[1], ad[2], wd[1], wd[3]);
      end
      total++;
      if ({rdy_setup, rdy_access} !== 2'b01) begin
         bad++; $display("FAIL b2b_ready got=%b exp=01", {rdy_setup, rdy_access});
      end
   endtask

   // Drives one command from IDLE and waits (bounded) for its response.
   task automatic run_xfer(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                           input int waits, input logic [DW-1:0] rd, input logic err,
                           output logic seen, output logic [DW-1:0] got_rdata, output logic got_err);
      cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata;
      pready = 1'b0; pslverr = 1'b0;
      tick();
      cmd_valid = 1'b0;
      tick();
      for (int w = 0; w < waits; w++) tick();
      pready = 1'b1; prdata = rd; pslverr = err;
      seen = 1'b0; got_rdata = 32'h0; got_err = 1'b0;
      for (int k = 0; k < 4 && !seen; k++) begin
         tick();
         pready = 1'b0; pslverr = 1'b0;
         if (rsp_valid === 1'b1) begin seen = 1'b1; got_rdata = rsp_rdata; got_err = rsp_err; end
      end
   endtask

   task automatic test_slverr();
      logic seen, gerr;
      logic [DW-1:0] grd;
      run_xfer(1'b0, 32'h30, 32'h0, 1, 32'h0BAD_0BAD, 1'b1, seen, grd, gerr);
      total++;
      if ({seen, gerr} !== 2'b11 || grd !== 32'h0BAD_0BAD) begin
         bad++; $display("FAIL slverr_rsp got=%b/%h exp=11/0bad0bad", {seen, gerr}, grd);
      end
      run_xfer(1'b1, 32'h34, 32'h5555_AAAA, 0, 32'hFFFF_FFFF, 1'b0, seen, grd, gerr);
      total++;
      if ({seen, gerr} !== 2'b10 || grd !== 32'h0) begin
         bad++; $display("FAIL slverr_next got=%b/%h exp=10/00000000", {seen, gerr}, grd);
      end
   endtask

   task automatic test_reset_mid();
      logic no_rsp;
      no_rsp = 1'b1;
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h40; pready = 1'b0;
      tick();
      cmd_valid = 1'b0;
      tick();
      total++;
      if ({psel, penable} !== 2'b11) begin bad++; $display("FAIL rstmid_pre got=%b exp=11", {psel, penable}); end
      reset = 1'b1;
      tick();
      total++;
      if ({psel, penable, rsp_valid, busy} !== 4'b0000) begin
         bad++; $display("FAIL rstmid_out got=%b exp=0000", {psel, penable, rsp_valid, busy});
      end
      reset = 1'b0; pready = 1'b1; pslverr = 1'b1;
      #1;
      total++;
      if (cmd_ready !== 1'b1) begin bad++; $display("FAIL rstmid_ready got=%b exp=1", cmd_ready); end
      for (int c = 0; c < 3; c++) begin
         tick();
         if (rsp_valid !== 1'b0 || psel !== 1'b0) no_rsp = 1'b0;
      end
      pready = 1'b0; pslverr = 1'b0;
      total++;
      if (no_rsp !== 1'b1) begin bad++; $display("FAIL rstmid_norsp got=%b exp=1", no_rsp); end
   endtask

   task automatic test_timeout();
      logic hold_ok;
      hold_ok = 1'b1;
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h50; pready = 1'b0; prdata = 32'hFFFF_FFFF;
      tick();
      cmd_valid = 1'b0;
`ifdef APBM_TIMEOUT_EN
      for (int c = 0; c < TMO; c++) begin
         tick();
         if ({psel, penable, rsp_valid} !== 3'b110) hold_ok = 1'b0;
         if (c == TMO - 1 && cmd_ready !== 1'b0) hold_ok = 1'b0;
      end
      total++;
      if (hold_ok !== 1'b1) begin bad++; $display("FAIL tmo_wait got=%b exp=1", hold_ok); end
      tick();
      total++;
      if ({rsp_valid, rsp_err, psel, penable, busy} !== 5'b11000 || rsp_rdata !== 32'h0) begin
         bad++; $display("FAIL tmo_abort got=%b/%h exp=11000/00000000", {rsp_valid, rsp_err, psel, penable, busy}, rsp_rdata);
      end
`else
      for (int c = 0; c < 20; c++) begin
         tick();
         if ({psel, penable, rsp_valid} !== 3'b110 || paddr !== 32'h50) hold_ok = 1'b0;
      end
      total++;
      if (hold_ok !== 1'b1) begin bad++; $display("FAIL notmo_hold got=%b exp=1", hold_ok); end
      pready = 1'b1; prdata = 32'h0000_CAFE; pslverr = 1'b0;
      tick();
      pready = 1'b0;
      total++;
      if ({rsp_valid, rsp_err} !== 2'b10 || rsp_rdata !== 32'h0000_CAFE) begin
         bad++; $display("FAIL notmo_rsp got=%b/%h exp=10/0000cafe", {rsp_valid, rsp_err}, rsp_rdata);
      end
`endif
   endtask

   // Random commands and slave behaviour against a queue-based transaction model.
   task automatic test_random();
      cmd_t          cq [$];
      cmd_t          cur, nc;
      logic          acc_prev, done_prev, exp_err, exp_ready;
      logic [DW-1:0] exp_rd;
      int            waits;
      acc_prev = 1'b0; done_prev = 1'b0; waits = 0; exp_rd = 32'h0; exp_err = 1'b0;
      cur = '{wr: 1'b0, addr: 32'h0, data: 32'h0};
      cmd_valid = 1'b0;
      for (int i = 0; i < 400; i++) begin
         tick();
         total++;
         if ((psel && !penable) !== acc_prev) begin
            bad++; $display("FAIL rnd_setup cyc=%0d got=%b exp=%b", i, psel && !penable, acc_prev);
         end
         if (psel && !penable && cq.size() > 0) begin
            cur = cq.pop_front();
            total++;
            if (pwrite !== cur.wr || paddr !== cur.addr || pwdata !== cur.data) begin
               bad++; $display("FAIL rnd_cmd cyc=%0d got=%b/%h/%h exp=%b/%h/%h", i, pwrite, paddr, pwdata, cur.wr, cur.addr, cur.data);
            end
         end
         if (psel && penable) begin
            total++;
            if (pwrite !== cur.wr || paddr !== cur.addr) begin
               bad++; $display("FAIL rnd_hold cyc=%0d got=%h exp=%h", i, paddr, cur.addr);
            end
         end
         total++;
         if (rsp_valid !== done_prev) begin
            bad++; $display("FAIL rnd_rspv cyc=%0d got=%b exp=%b", i, rsp_valid, done_prev);
         end
         if (rsp_valid && done_prev) begin
            total++;
            if (rsp_rdata !== exp_rd || rsp_err !== exp_err) begin
               bad++; $display("FAIL rnd_rsp cyc=%0d got=%h/%b exp=%h/%b", i, rsp_rdata, rsp_err, exp_rd, exp_err);
            end
         end
         total++;
         if (busy !== psel) begin bad++; $display("FAIL rnd_busy cyc=%0d got=%b exp=%b", i, busy, psel); end
         if (psel && penable) begin
            pready = (waits >= 3) ? 1'b1 : ($urandom_range(0, 2) != 0);
            waits  = pready ? 0 : waits + 1;
         end else begin
            pready = 1'($urandom_range(0, 1));
         end
         prdata  = $urandom;
         pslverr = 1'($urandom_range(0, 1));
         if (acc_prev || !cmd_valid) begin
            if (i < 380 && $urandom_range(0, 3) != 0) begin
               cmd_valid = 1'b1; cmd_write = 1'($urandom_range(0, 1));
               cmd_addr = $urandom; cmd_wdata = $urandom;
            end else begin
               cmd_valid = 1'b0;
            end
         end
         #1;
         exp_ready = !psel || (psel && penable && pready);
         total++;
         if (cmd_ready !== exp_ready) begin
            bad++; $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", i, cmd_ready, exp_ready);
         end
         acc_prev = cmd_valid && exp_ready;
         if (acc_prev) begin
            nc = '{wr: cmd_write, addr: cmd_addr, data: cmd_wdata};
            cq.push_back(nc);
         end
         done_prev = psel && penable && pready;
         if (done_prev) begin
            exp_rd  = cur.wr ? 32'h0 : prdata;
            exp_err = pslverr;
         end
      end
      cmd_valid = 1'b0; pready = 1'b0;
      total++;
      if (cq.size() != 0 || busy !== 1'b0) begin
         bad++; $display("FAIL rnd_drain got=%0d/%b exp=0/0", cq.size(), busy);
      end
   endtask

   initial begin
      pclk = 1'b0; reset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0;
      cmd_addr = 32'h0; cmd_wdata = 32'h0; prdata = 32'h0; pready = 1'b0; pslverr = 1'b0;
      test_reset();
      test_write();
      test_read_wait();
      test_back_to_back();
      test_slverr();
      test_reset_mid();
      test_timeout();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

endmodule
